// File: rtl/sdf_pipe_test.sv
// rtl/sdf_pipe_test.sv - multi-lane pipelined buf/inv/AND/OR/NAND cone with valid, hold and sample counter
// Optional registered parity output enabled by SDF_PIPE_PARITY_EN.
module sdf_pipe_test #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             en,
    input  logic             in_valid,
    input  logic             hold,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic             out_valid,
`ifdef SDF_PIPE_PARITY_EN
    output logic             parity,
`endif
    output logic [CNT_W-1:0] sample_cnt
);

    logic [WIDTH-1:0] n3, n4, n5, n6;
    logic [WIDTH-1:0] s_or   [STAGES];
    logic [WIDTH-1:0] s_nand [STAGES];
    logic [WIDTH-1:0] s_and  [STAGES];
    logic [STAGES-1:0] s_vld;
    logic [CNT_W-1:0]  cnt;

    assign n3 = ~d1;
    assign n4 = d1 & d2;
    assign n5 = n3 | n4;
    assign n6 = ~(n5 & {WIDTH{en}});

    // Valid bits always shift; data only loads behind a valid bit so bubbles keep the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                s_or[k]   <= '0;
                s_nand[k] <= '0;
                s_and[k]  <= '0;
            end
            s_vld <= '0;
            cnt   <= '0;
        end else if (!hold) begin
            s_vld[0] <= in_valid;
            if (in_valid) begin
                s_or[0]   <= n5;
                s_nand[0] <= n6;
                s_and[0]  <= n4;
                cnt       <= cnt + 1'b1;
            end
            for (int k = 1; k < STAGES; k++) begin
                s_vld[k] <= s_vld[k-1];
                if (s_vld[k-1]) begin
                    s_or[k]   <= s_or[k-1];
                    s_nand[k] <= s_nand[k-1];
                    s_and[k]  <= s_and[k-1];
                end
            end
        end
    end

    assign q1         = s_or[STAGES-1];
    assign q2         = s_nand[STAGES-1];
    assign q3         = s_and[STAGES-1];
    assign out_valid  = s_vld[STAGES-1];
    assign sample_cnt = cnt;

`ifdef SDF_PIPE_PARITY_EN
    logic [WIDTH-1:0] enter_or, enter_nand, enter_and;
    logic             enter_vld;

    // The word about to load the last stage: straight from the cone when there is only one stage.
    if (STAGES == 1) begin : g_enter
        assign enter_vld  = in_valid;
        assign enter_or   = n5;
        assign enter_nand = n6;
        assign enter_and  = n4;
    end else begin : g_enter
        assign enter_vld  = s_vld[STAGES-2];
        assign enter_or   = s_or[STAGES-2];
        assign enter_nand = s_nand[STAGES-2];
        assign enter_and  = s_and[STAGES-2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (!hold && enter_vld) begin
            parity <= ^{enter_or, enter_nand, enter_and};
        end
    end
`endif

endmodule

// File: tb/tb_sdf_pipe_test.sv
// tb/tb_sdf_pipe_test.sv - scoreboard bench for sdf_pipe_test (WIDTH=4, STAGES=2, CNT_W=4)
module tb_sdf_pipe_test;
    localparam int W = 4;
    localparam int S = 2;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] d1 = '0;
    logic [W-1:0] d2 = '0;
    logic         en = 1'b0;
    logic         in_valid = 1'b0;
    logic         hold = 1'b0;
    logic [W-1:0] q1, q2, q3;
    logic         out_valid;
    logic [C-1:0] sample_cnt;
`ifdef SDF_PIPE_PARITY_EN
    logic         parity;
`endif

    int checks = 0;
    int failures = 0;
    logic [3*W-1:0] exp_q[$];
    logic [3*W-1:0] e;

    sdf_pipe_test #(.WIDTH(W), .STAGES(S), .CNT_W(C)) dut (
        .clk(clk), .rst_n(rst_n), .d1(d1), .d2(d2), .en(en),
        .in_valid(in_valid), .hold(hold),
        .q1(q1), .q2(q2), .q3(q3), .out_valid(out_valid),
`ifdef SDF_PIPE_PARITY_EN
        .parity(parity),
`endif
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one word; expected {q1,q2,q3} is hand-computed by the caller.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic e_n,
                        input logic [W-1:0] x1, input logic [W-1:0] x2, input logic [W-1:0] x3);
        d1 = a; d2 = b; en = e_n; in_valid = 1'b1;
        exp_q.push_back({x1, x2, x3});
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_q1", 32'(q1), 32'(e[11:8]));
                check("sb_q2", 32'(q2), 32'(e[7:4]));
                check("sb_q3", 32'(q3), 32'(e[3:0]));
`ifdef SDF_PIPE_PARITY_EN
                check("sb_parity", 32'(parity), 32'(^e));
`endif
            end
        end
    end

    initial begin
        // Reset held across edges
        step(); step();
        check("rst_q1", 32'(q1), 32'h0);
        check("rst_q2", 32'(q2), 32'h0);
        check("rst_q3", 32'(q3), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_cnt", 32'(sample_cnt), 32'h0);
        rst_n = 1'b1;

        // Basic word, latency 2
        send(4'b0101, 4'b0011, 1'b1, 4'b1011, 4'b0100, 4'b0001);
        step();
        in_valid = 1'b0;
        check("basic_lat1_valid", 32'(out_valid), 32'h0);
        check("basic_cnt", 32'(sample_cnt), 32'h1);
        step();
        check("basic_valid", 32'(out_valid), 32'h1);
        check("basic_q1", 32'(q1), 32'hB);
        check("basic_q2", 32'(q2), 32'h4);
        check("basic_q3", 32'(q3), 32'h1);
`ifdef SDF_PIPE_PARITY_EN
        check("basic_parity", 32'(parity), 32'h1);
`endif
        step();
        check("basic_after_valid", 32'(out_valid), 32'h0);
        check("basic_after_q1", 32'(q1), 32'hB);

        // Asynchronous reset between edges
        #1 rst_n = 1'b0;
        #1;
        check("async_q1", 32'(q1), 32'h0);
        check("async_q3", 32'(q3), 32'h0);
        check("async_cnt", 32'(sample_cnt), 32'h0);
        rst_n = 1'b1;
        step();

        // Back-to-back words with en 1,0,1
        send(4'b0101, 4'b0011, 1'b1, 4'b1011, 4'b0100, 4'b0001);
        step();
        send(4'b0101, 4'b0011, 1'b0, 4'b1011, 4'b1111, 4'b0001);
        step();
        check("b2b_q2_w1", 32'(q2), 32'h4);
        send(4'b0101, 4'b0011, 1'b1, 4'b1011, 4'b0100, 4'b0001);
        step();
        in_valid = 1'b0;
        check("b2b_q2_w2", 32'(q2), 32'hF);
        step();
        check("b2b_q2_w3", 32'(q2), 32'h4);
        check("b2b_cnt", 32'(sample_cnt), 32'h3);
        step();

        // Hold: one word accepted, then frozen for 3 edges with in_valid ignored
        send(4'b0011, 4'b0110, 1'b1, 4'b1110, 4'b0001, 4'b0010);
        step();
        hold = 1'b1;
        d1 = 4'b1001; d2 = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_valid", 32'(out_valid), 32'h0);
            check("hold_q2", 32'(q2), 32'h4);
            check("hold_cnt", 32'(sample_cnt), 32'h4);
        end
        hold = 1'b0;
        in_valid = 1'b0;
        step();
        check("hold_release_valid", 32'(out_valid), 32'h1);
        check("hold_release_q1", 32'(q1), 32'hE);
        step();

        // Counter wrap over 17 words
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            send(4'b0101, 4'b0011, 1'b1, 4'b1011, 4'b0100, 4'b0001);
            step();
            if (i == 15) check("wrap_cnt15", 32'(sample_cnt), 32'd15);
            if (i == 16) check("wrap_cnt16", 32'(sample_cnt), 32'd0);
            if (i == 17) check("wrap_cnt17", 32'(sample_cnt), 32'd1);
        end
        in_valid = 1'b0;
        step(); step(); step();

        // Reset with two words in flight discards them
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        send(4'b0101, 4'b0011, 1'b1, 4'b1011, 4'b0100, 4'b0001);
        step();
        send(4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b1111, 4'b0000);
        step();
        rst_n = 1'b0;
        exp_q.delete();
        in_valid = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("midrst_after_valid", 32'(out_valid), 32'h0);
        check("midrst_cnt", 32'(sample_cnt), 32'h0);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
